// File: rtl/gpu_exec_ctrl_if.sv
// Control/status handshake between the GPU control register block, the
// instruction-issue unit and gpu_exec_ctrl. The controller sits on the slave side.
interface gpu_exec_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             go;
    logic             single_step;
    logic             single_go;
    logic             cpu_int;
    logic             int_ack;
    logic             issue_take;
    logic             instr_done;
    logic             pipe_idle;
    logic             issue_en;
    logic             single_stop;
    logic             cpu_irq;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output go, single_step, single_go, cpu_int, int_ack,
               issue_take, instr_done, pipe_idle,
        input  issue_en, single_stop, cpu_irq, instr_count
    );

    modport slave (
        input  go, single_step, single_go, cpu_int, int_ack,
               issue_take, instr_done, pipe_idle,
        output issue_en, single_stop, cpu_irq, instr_count
    );
endinterface

// File: rtl/gpu_exec_ctrl.sv
// GPU execution controller: gates instruction issue (free run / drain-stop /
// single step), counts retired instructions and holds the GPU->CPU interrupt
// as a level until the host acknowledges it.
module gpu_exec_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    gpu_exec_ctrl_if.slave ctrl
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        RUN         = 3'd1,
        STOP        = 3'd2,
        STEP_WAIT   = 3'd3,
        STEP_ISSUE  = 3'd4,
        STEP_RETIRE = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_nxt;
    logic             r_issue_en;
    logic             r_single_stop;
    logic             r_step_pend;
    logic             w_step_pend_nxt;
    logic             r_go_d;
    logic             r_cpu_irq;
    logic [CNT_W-1:0] r_instr_count;

    // Next-state decode; first matching condition per state wins.
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (ctrl.go && ctrl.single_step) w_nxt = STEP_WAIT;
                else if (ctrl.go)                w_nxt = RUN;
            end
            RUN: begin
                if (!ctrl.go || ctrl.single_step) w_nxt = STOP;
            end
            STOP: begin
                // Issue is off here; wait for in-flight work to drain.
                if (ctrl.pipe_idle && !ctrl.go)              w_nxt = IDLE;
                else if (ctrl.pipe_idle && ctrl.single_step) w_nxt = STEP_WAIT;
                else if (ctrl.pipe_idle)                     w_nxt = RUN;
            end
            STEP_WAIT: begin
                if (!ctrl.go)               w_nxt = IDLE;
                else if (!ctrl.single_step) w_nxt = RUN;
                else if (r_step_pend)       w_nxt = STEP_ISSUE;
            end
            STEP_ISSUE: begin
                if (!ctrl.go)             w_nxt = IDLE;
                else if (ctrl.issue_take) w_nxt = STEP_RETIRE;
            end
            STEP_RETIRE: begin
                if (!ctrl.go)             w_nxt = STOP;
                else if (ctrl.instr_done) w_nxt = STEP_WAIT;
            end
            default: w_nxt = IDLE;
        endcase
    end

    // Sticky single_go: a pulse landing on the step-start cycle survives the
    // entry clear, so it queues exactly one more step.
    always_comb begin
        w_step_pend_nxt = r_step_pend;
        if (!ctrl.go || !ctrl.single_step)
            w_step_pend_nxt = 1'b0;
        else if (ctrl.single_go && (r_state != IDLE))
            w_step_pend_nxt = 1'b1;
        else if ((w_nxt == STEP_ISSUE) && (r_state != STEP_ISSUE))
            w_step_pend_nxt = 1'b0;
    end

    // State register with outputs registered from the next state, so they
    // are exact Moore decodes of r_state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_issue_en    <= 1'b0;
            r_single_stop <= 1'b0;
            r_step_pend   <= 1'b0;
        end else begin
            r_state       <= w_nxt;
            r_issue_en    <= (w_nxt == RUN) || (w_nxt == STEP_ISSUE);
            r_single_stop <= (w_nxt == STEP_WAIT);
            r_step_pend   <= w_step_pend_nxt;
        end
    end

    // Retired-instruction counter, restarted on each rising edge of go.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_go_d        <= 1'b0;
            r_instr_count <= '0;
        end else begin
            r_go_d <= ctrl.go;
            if (ctrl.go && !r_go_d)
                r_instr_count <= ctrl.instr_done ? CNT_W'(1) : '0;
            else if (ctrl.instr_done)
                r_instr_count <= r_instr_count + CNT_W'(1);
        end
    end

    // Interrupt latch; a new request beats a simultaneous acknowledge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)          r_cpu_irq <= 1'b0;
        else if (ctrl.cpu_int) r_cpu_irq <= 1'b1;
        else if (ctrl.int_ack) r_cpu_irq <= 1'b0;
    end

    assign ctrl.issue_en    = r_issue_en;
    assign ctrl.single_stop = r_single_stop;
    assign ctrl.cpu_irq     = r_cpu_irq;
    assign ctrl.instr_count = r_instr_count;

endmodule

// File: tb/tb_gpu_exec_ctrl.sv
// Bench for gpu_exec_ctrl: a table of per-cycle input/expected-output rows
// fed through a scoreboard queue, plus hand-written reset sequences.
module tb_gpu_exec_ctrl;
    localparam int CNT_W = 4;

    logic clk;
    logic reset_n;
    int   n_run;
    int   n_fail;

    gpu_exec_ctrl_if #(.CNT_W(CNT_W)) bus ();

    gpu_exec_ctrl #(.CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ctrl    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // in  = {go, single_step, single_go, cpu_int, int_ack, issue_take, instr_done, pipe_idle}
    // ex  = {issue_en, single_stop, cpu_irq}
    typedef struct {
        logic [7:0] in;
        logic [2:0] ex;
        int         cnt;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    function automatic vec_t mk(input logic [7:0] in, input logic [2:0] ex, input int cnt);
        vec_t v;
        v.in  = in;
        v.ex  = ex;
        v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] in);
        {bus.go, bus.single_step, bus.single_go, bus.cpu_int,
         bus.int_ack, bus.issue_take, bus.instr_done, bus.pipe_idle} = in;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t e;
        n_run  = 0;
        n_fail = 0;

        // A: free run, drain stop, go-edge counter restart
        tbl.push_back(mk(8'b1000_0001, 3'b100, 0));
        for (int k = 1; k <= 5; k++) tbl.push_back(mk(8'b1000_0011, 3'b100, k));
        tbl.push_back(mk(8'b1000_0001, 3'b100, 5));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(8'b0000_0000, 3'b000, 5));
        tbl.push_back(mk(8'b0000_0001, 3'b000, 5));
        tbl.push_back(mk(8'b1000_0001, 3'b100, 0));
        tbl.push_back(mk(8'b0000_0001, 3'b000, 0));
        tbl.push_back(mk(8'b0000_0001, 3'b000, 0));
        tbl.push_back(mk(8'b1000_0011, 3'b100, 1));   // restart + retire same cycle
        tbl.push_back(mk(8'b0000_0001, 3'b000, 1));
        tbl.push_back(mk(8'b0000_0001, 3'b000, 1));
        // B: single step with 2-cycle issue latency, one take honoured
        tbl.push_back(mk(8'b1100_0001, 3'b010, 0));
        tbl.push_back(mk(8'b1100_0001, 3'b010, 0));
        tbl.push_back(mk(8'b1110_0001, 3'b010, 0));
        tbl.push_back(mk(8'b1100_0001, 3'b100, 0));
        tbl.push_back(mk(8'b1100_0001, 3'b100, 0));
        tbl.push_back(mk(8'b1100_0101, 3'b000, 0));
        tbl.push_back(mk(8'b1100_0101, 3'b000, 0));
        tbl.push_back(mk(8'b1100_0011, 3'b010, 1));
        tbl.push_back(mk(8'b1100_0001, 3'b010, 1));
        tbl.push_back(mk(8'b1100_0001, 3'b010, 1));
        // C: pulse on step-start cycle queues one more; extra pulses collapse
        tbl.push_back(mk(8'b1110_0001, 3'b010, 1));
        tbl.push_back(mk(8'b1110_0001, 3'b100, 1));
        tbl.push_back(mk(8'b1100_0101, 3'b000, 1));
        tbl.push_back(mk(8'b1110_0001, 3'b000, 1));
        tbl.push_back(mk(8'b1100_0011, 3'b010, 2));
        tbl.push_back(mk(8'b1100_0001, 3'b100, 2));
        tbl.push_back(mk(8'b1100_0101, 3'b000, 2));
        tbl.push_back(mk(8'b1100_0011, 3'b010, 3));
        tbl.push_back(mk(8'b1100_0001, 3'b010, 3));
        tbl.push_back(mk(8'b1100_0001, 3'b010, 3));
        // D: go drop in STEP_ISSUE goes straight to IDLE
        tbl.push_back(mk(8'b1110_0001, 3'b010, 3));
        tbl.push_back(mk(8'b1100_0001, 3'b100, 3));
        tbl.push_back(mk(8'b0100_0001, 3'b000, 3));
        tbl.push_back(mk(8'b0000_0001, 3'b000, 3));
        // E: enter step from RUN with a busy pipe, then leave step mode
        tbl.push_back(mk(8'b1000_0001, 3'b100, 0));
        tbl.push_back(mk(8'b1000_0011, 3'b100, 1));
        for (int k = 0; k < 4; k++) tbl.push_back(mk(8'b1100_0000, 3'b000, 1));
        tbl.push_back(mk(8'b1100_0001, 3'b010, 1));
        tbl.push_back(mk(8'b1000_0001, 3'b100, 1));
        tbl.push_back(mk(8'b1000_0001, 3'b100, 1));
        // F: go drop in STEP_RETIRE drains through STOP
        tbl.push_back(mk(8'b1100_0001, 3'b000, 1));
        tbl.push_back(mk(8'b1100_0001, 3'b010, 1));
        tbl.push_back(mk(8'b1110_0001, 3'b010, 1));
        tbl.push_back(mk(8'b1100_0001, 3'b100, 1));
        tbl.push_back(mk(8'b1100_0101, 3'b000, 1));
        tbl.push_back(mk(8'b0100_0000, 3'b000, 1));
        tbl.push_back(mk(8'b0000_0000, 3'b000, 1));
        tbl.push_back(mk(8'b0000_0001, 3'b000, 1));
        tbl.push_back(mk(8'b1000_0001, 3'b100, 0));
        // G: interrupt latch, set beats ack
        tbl.push_back(mk(8'b1001_0001, 3'b101, 0));
        tbl.push_back(mk(8'b1000_0001, 3'b101, 0));
        tbl.push_back(mk(8'b1000_0001, 3'b101, 0));
        tbl.push_back(mk(8'b1000_1001, 3'b100, 0));
        tbl.push_back(mk(8'b1000_0001, 3'b100, 0));
        tbl.push_back(mk(8'b1001_1001, 3'b101, 0));
        tbl.push_back(mk(8'b1000_1001, 3'b100, 0));
        tbl.push_back(mk(8'b1000_0001, 3'b100, 0));
        // H: counter wraps modulo 2^CNT_W
        for (int k = 1; k <= 17; k++) tbl.push_back(mk(8'b1000_0011, 3'b100, k % 16));

        // Reset held with go=1
        drive(8'b1000_0001);
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst issue_en",    int'(bus.issue_en),    0);
        chk("rst single_stop", int'(bus.single_stop), 0);
        chk("rst cpu_irq",     int'(bus.cpu_irq),     0);
        chk("rst instr_count", int'(bus.instr_count), 0);
        reset_n = 1'b1;

        // Table through the scoreboard
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].in);
            exp_q.push_back(tbl[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            chk($sformatf("row%0d issue_en", i),    int'(bus.issue_en),    int'(e.ex[2]));
            chk($sformatf("row%0d single_stop", i), int'(bus.single_stop), int'(e.ex[1]));
            chk($sformatf("row%0d cpu_irq", i),     int'(bus.cpu_irq),     int'(e.ex[0]));
            chk($sformatf("row%0d instr_count", i), int'(bus.instr_count), e.cnt);
        end

        // Mid-operation asynchronous reset: everything clears at once
        drive(8'b1001_0001);
        @(posedge clk);
        #1;
        chk("pre-rst cpu_irq", int'(bus.cpu_irq), 1);
        drive(8'b1000_0011);
        #2 reset_n = 1'b0;
        #1;
        chk("async rst issue_en",    int'(bus.issue_en),    0);
        chk("async rst cpu_irq",     int'(bus.cpu_irq),     0);
        chk("async rst instr_count", int'(bus.instr_count), 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        drive(8'b0000_0001);
        @(posedge clk);
        #1;
        chk("post-rst idle issue_en", int'(bus.issue_en),    0);
        chk("post-rst instr_count",   int'(bus.instr_count), 0);
        chk("post-rst cpu_irq",       int'(bus.cpu_irq),     0);
        drive(8'b1000_0001);
        @(posedge clk);
        #1;
        chk("post-rst run issue_en", int'(bus.issue_en), 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
